riscv_core_branch_predictor: RTL and testbench

//  Dynamic branch predictor driving the fetch-stage next-PC mux: direct-mapped BTB + 2-bit

---
 rtl/riscv_core_branch_predictor.sv | 160 ++++++++++++++++
 tb/tb_riscv_core_branch_predictor.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/riscv_core_branch_predictor.sv
// Direct-mapped BTB with 2-bit saturating direction counters for the IF-stage next-PC mux.
// Define RISCV_BP_GSHARE_EN to XOR a global history register into the counter index.
module riscv_core_branch_predictor #(
  parameter int unsigned ADDRLEN = 32,
  parameter int unsigned ENTRIES = 16,
  parameter int unsigned CNTW    = 32
) (
  input  logic                       i_clk,
  input  logic                       i_rst,
  input  logic [ADDRLEN-1:0]         i_fetch_pc,
  output logic                       o_valid,
  output logic                       o_isTaken,
  output logic [ADDRLEN-1:0]         o_predictedAddr,
  output logic [$clog2(ENTRIES)-1:0] o_pred_idx,
  input  logic                       i_ex_branch,
  input  logic [ADDRLEN-1:0]         i_ex_pc,
  input  logic [ADDRLEN-1:0]         i_ex_pc_plus,
  input  logic                       i_ex_taken,
  input  logic [ADDRLEN-1:0]         i_ex_target,
  input  logic                       i_ex_pred_taken,
  input  logic [ADDRLEN-1:0]         i_ex_pred_addr,
  input  logic [$clog2(ENTRIES)-1:0] i_ex_pred_idx,
  output logic                       o_misprediction,
  output logic [ADDRLEN-1:0]         o_recoveredAddr,
  output logic [CNTW-1:0]            o_branch_cnt,
  output logic [CNTW-1:0]            o_mispred_cnt
);

  localparam int unsigned IDXW = $clog2(ENTRIES);
  localparam int unsigned TAGW = ADDRLEN - 1 - IDXW;

  logic               valid_q  [ENTRIES];
  logic               valid_d  [ENTRIES];
  logic [TAGW-1:0]    tag_q    [ENTRIES];
  logic [TAGW-1:0]    tag_d    [ENTRIES];
  logic [ADDRLEN-1:0] target_q [ENTRIES];
  logic [ADDRLEN-1:0] target_d [ENTRIES];
  logic [1:0]         ctr_q    [ENTRIES];
  logic [1:0]         ctr_d    [ENTRIES];
  logic [CNTW-1:0]    branch_cnt_q, branch_cnt_d;
  logic [CNTW-1:0]    mispred_cnt_q, mispred_cnt_d;

  logic [IDXW-1:0] bidx, uidx;
  logic [TAGW-1:0] ftag, utag;
  logic            fhit, uhit, mis;

  // PC bit 0 is always zero for RVC-aligned fetch and carries no index/tag information.
  logic unused_pc_lsb;
  assign unused_pc_lsb = i_fetch_pc[0] ^ i_ex_pc[0];

  assign bidx = i_fetch_pc[IDXW:1];
  assign ftag = i_fetch_pc[ADDRLEN-1:IDXW+1];
  assign uidx = i_ex_pc[IDXW:1];
  assign utag = i_ex_pc[ADDRLEN-1:IDXW+1];
  assign fhit = valid_q[bidx] && (tag_q[bidx] == ftag);
  assign uhit = valid_q[uidx] && (tag_q[uidx] == utag);

`ifdef RISCV_BP_GSHARE_EN
  logic [IDXW-1:0] ghr_q, ghr_d;

  assign o_pred_idx = bidx ^ ghr_q;

  always_comb begin
    ghr_d = ghr_q;
    if (i_ex_branch) begin
      ghr_d = {ghr_q[IDXW-2:0], i_ex_taken};
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      ghr_q <= '0;
    end else begin
      ghr_q <= ghr_d;
    end
  end
`else
  assign o_pred_idx = bidx;
`endif

  always_comb begin
    o_valid         = 1'b0;
    o_isTaken       = 1'b0;
    o_predictedAddr = '0;
    if (!i_rst && fhit) begin
      o_valid         = 1'b1;
      o_isTaken       = ctr_q[o_pred_idx][1];
      o_predictedAddr = target_q[bidx];
    end
  end

  assign mis = (i_ex_taken != i_ex_pred_taken) ||
               (i_ex_taken && (i_ex_pred_addr != i_ex_target));

  always_comb begin
    o_misprediction = 1'b0;
    o_recoveredAddr = '0;
    if (!i_rst && i_ex_branch && mis) begin
      o_misprediction = 1'b1;
      o_recoveredAddr = i_ex_taken ? i_ex_target : i_ex_pc_plus;
    end
  end

  always_comb begin
    valid_d       = valid_q;
    tag_d         = tag_q;
    target_d      = target_q;
    ctr_d         = ctr_q;
    branch_cnt_d  = branch_cnt_q;
    mispred_cnt_d = mispred_cnt_q;
    if (i_ex_branch) begin
      if (uhit) begin
        if (i_ex_taken) begin
          target_d[uidx] = i_ex_target;
          if (ctr_q[i_ex_pred_idx] != 2'b11) begin
            ctr_d[i_ex_pred_idx] = ctr_q[i_ex_pred_idx] + 2'd1;
          end
        end else if (ctr_q[i_ex_pred_idx] != 2'b00) begin
          ctr_d[i_ex_pred_idx] = ctr_q[i_ex_pred_idx] - 2'd1;
        end
      end else if (i_ex_taken) begin
        // New entries start weakly taken so a second taken resolve already predicts taken.
        valid_d[uidx]        = 1'b1;
        tag_d[uidx]          = utag;
        target_d[uidx]       = i_ex_target;
        ctr_d[i_ex_pred_idx] = 2'b10;
      end
      if (branch_cnt_q != {CNTW{1'b1}}) begin
        branch_cnt_d = branch_cnt_q + 1'b1;
      end
      if (mis && (mispred_cnt_q != {CNTW{1'b1}})) begin
        mispred_cnt_d = mispred_cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      for (int i = 0; i < ENTRIES; i++) begin
        valid_q[i]  <= 1'b0;
        tag_q[i]    <= '0;
        target_q[i] <= '0;
        ctr_q[i]    <= 2'b01;
      end
      branch_cnt_q  <= '0;
      mispred_cnt_q <= '0;
    end else begin
      valid_q       <= valid_d;
      tag_q         <= tag_d;
      target_q      <= target_d;
      ctr_q         <= ctr_d;
      branch_cnt_q  <= branch_cnt_d;
      mispred_cnt_q <= mispred_cnt_d;
    end
  end

  assign o_branch_cnt  = branch_cnt_q;
  assign o_mispred_cnt = mispred_cnt_q;

endmodule

// File: tb/tb_riscv_core_branch_predictor.sv
// Randomized bench comparing the branch predictor against an array-based reference model.
module tb_riscv_core_branch_predictor;

  localparam int unsigned ADDRLEN = 32;
  localparam int unsigned ENTRIES = 16;
  localparam int unsigned CNTW    = 4;
  localparam int unsigned IDXW    = $clog2(ENTRIES);
  localparam int unsigned CNTMAX  = (1 << CNTW) - 1;

  logic               clk;
  logic               i_rst;
  logic [ADDRLEN-1:0] i_fetch_pc;
  logic               o_valid, o_isTaken;
  logic [ADDRLEN-1:0] o_predictedAddr;
  logic [IDXW-1:0]    o_pred_idx;
  logic               i_ex_branch, i_ex_taken, i_ex_pred_taken;
  logic [ADDRLEN-1:0] i_ex_pc, i_ex_pc_plus, i_ex_target, i_ex_pred_addr;
  logic [IDXW-1:0]    i_ex_pred_idx;
  logic               o_misprediction;
  logic [ADDRLEN-1:0] o_recoveredAddr;
  logic [CNTW-1:0]    o_branch_cnt, o_mispred_cnt;

  riscv_core_branch_predictor #(
    .ADDRLEN(ADDRLEN),
    .ENTRIES(ENTRIES),
    .CNTW   (CNTW)
  ) dut (
    .i_clk          (clk),
    .i_rst          (i_rst),
    .i_fetch_pc     (i_fetch_pc),
    .o_valid        (o_valid),
    .o_isTaken      (o_isTaken),
    .o_predictedAddr(o_predictedAddr),
    .o_pred_idx     (o_pred_idx),
    .i_ex_branch    (i_ex_branch),
    .i_ex_pc        (i_ex_pc),
    .i_ex_pc_plus   (i_ex_pc_plus),
    .i_ex_taken     (i_ex_taken),
    .i_ex_target    (i_ex_target),
    .i_ex_pred_taken(i_ex_pred_taken),
    .i_ex_pred_addr (i_ex_pred_addr),
    .i_ex_pred_idx  (i_ex_pred_idx),
    .o_misprediction(o_misprediction),
    .o_recoveredAddr(o_recoveredAddr),
    .o_branch_cnt   (o_branch_cnt),
    .o_mispred_cnt  (o_mispred_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int unsigned n_vec = 0;
  int unsigned n_err = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: plain arrays indexed by (pc/2) mod ENTRIES, tag = pc / (2*ENTRIES).
  bit          m_valid  [ENTRIES];
  int unsigned m_tag    [ENTRIES];
  int unsigned m_target [ENTRIES];
  int          m_ctr    [ENTRIES];
  int unsigned m_ghr, m_bcnt, m_mcnt;

  function automatic int unsigned m_idx(input int unsigned pc);
    return (pc / 2) % ENTRIES;
  endfunction

  function automatic int unsigned m_tagof(input int unsigned pc);
    return pc / (2 * ENTRIES);
  endfunction

  function automatic int unsigned m_pidx(input int unsigned pc);
`ifdef RISCV_BP_GSHARE_EN
    return m_idx(pc) ^ m_ghr;
`else
    return m_idx(pc);
`endif
  endfunction

  function automatic bit m_hit(input int unsigned pc);
    return m_valid[m_idx(pc)] && (m_tag[m_idx(pc)] == m_tagof(pc));
  endfunction

  task automatic model_reset();
    for (int i = 0; i < ENTRIES; i++) begin
      m_valid[i] = 0; m_tag[i] = 0; m_target[i] = 0; m_ctr[i] = 1;
    end
    m_ghr = 0; m_bcnt = 0; m_mcnt = 0;
  endtask

  // Drive one cycle, compare all outputs mid-cycle, then advance model and DUT together.
  task automatic step(input int unsigned fpc, input bit exb, input int unsigned expc,
                      input bit tk, input int unsigned tgt, input bit ptk,
                      input int unsigned paddr, input int unsigned pidx);
    bit          fhit, mis;
    int unsigned ui, e_rec;
    i_fetch_pc      = fpc;
    i_ex_branch     = exb;
    i_ex_pc         = expc;
    i_ex_pc_plus    = expc + 4;
    i_ex_taken      = tk;
    i_ex_target     = tgt;
    i_ex_pred_taken = ptk;
    i_ex_pred_addr  = paddr;
    i_ex_pred_idx   = pidx[IDXW-1:0];
    @(negedge clk);
    fhit = m_hit(fpc);
    mis  = (tk != ptk) || (tk && paddr != tgt);
    e_rec = (exb && mis) ? (tk ? tgt : expc + 4) : 0;
    check_eq("valid", 64'(o_valid), 64'(fhit));
    check_eq("isTaken", 64'(o_isTaken), 64'(fhit && m_ctr[m_pidx(fpc)] >= 2));
    check_eq("predAddr", 64'(o_predictedAddr), fhit ? 64'(m_target[m_idx(fpc)]) : 64'd0);
    check_eq("predIdx", 64'(o_pred_idx), 64'(m_pidx(fpc)));
    check_eq("mispred", 64'(o_misprediction), 64'(exb && mis));
    check_eq("recAddr", 64'(o_recoveredAddr), 64'(e_rec));
    check_eq("branchCnt", 64'(o_branch_cnt), 64'(m_bcnt));
    check_eq("mispredCnt", 64'(o_mispred_cnt), 64'(m_mcnt));
    if (exb) begin
      ui = m_idx(expc);
      if (m_hit(expc)) begin
        if (tk) begin
          m_target[ui] = tgt;
          if (m_ctr[pidx] < 3) m_ctr[pidx]++;
        end else if (m_ctr[pidx] > 0) begin
          m_ctr[pidx]--;
        end
      end else if (tk) begin
        m_valid[ui] = 1; m_tag[ui] = m_tagof(expc); m_target[ui] = tgt; m_ctr[pidx] = 2;
      end
      if (m_bcnt < CNTMAX) m_bcnt++;
      if (mis && m_mcnt < CNTMAX) m_mcnt++;
      m_ghr = ((m_ghr << 1) | tk) % ENTRIES;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic check_reset_outputs(input string tag);
    check_eq({tag, "_valid"}, 64'(o_valid), 64'd0);
    check_eq({tag, "_isTaken"}, 64'(o_isTaken), 64'd0);
    check_eq({tag, "_predAddr"}, 64'(o_predictedAddr), 64'd0);
    check_eq({tag, "_mispred"}, 64'(o_misprediction), 64'd0);
    check_eq({tag, "_recAddr"}, 64'(o_recoveredAddr), 64'd0);
  endtask

  initial begin
    int unsigned pc, pi, tg;
    bit          tk, ptk;
    i_rst = 1'b1;
    i_fetch_pc = 32'h100; i_ex_branch = 1'b1; i_ex_pc = 32'h100; i_ex_pc_plus = 32'h104;
    i_ex_taken = 1'b1; i_ex_target = 32'h80; i_ex_pred_taken = 1'b0; i_ex_pred_addr = '0;
    i_ex_pred_idx = '0;
    model_reset();
    #2;
    check_reset_outputs("rst");
    check_eq("rst_branchCnt", 64'(o_branch_cnt), 64'd0);
    check_eq("rst_mispredCnt", 64'(o_mispred_cnt), 64'd0);
    @(posedge clk);
    #2;
    i_rst = 1'b0;
    i_ex_branch = 1'b0;
    @(posedge clk);
    #1;

    step(32'h100, 0, 0, 0, 0, 0, 0, 0);
    // Allocate on taken miss, then hit weakly-taken.
    step(32'h100, 1, 32'h100, 1, 32'h80, 0, 0, m_pidx(32'h100));
    step(32'h100, 0, 0, 0, 0, 0, 0, 0);
    // Two not-taken resolves: counter 2 -> 1 -> 0.
    pi = m_pidx(32'h100);
    step(32'h100, 1, 32'h100, 0, 32'h80, 1, 32'h80, pi);
    pi = m_pidx(32'h100);
    step(32'h100, 1, 32'h100, 0, 32'h80, 0, 0, pi);
    step(32'h100, 0, 0, 0, 0, 0, 0, 0);
    // Correct direction, wrong target.
    pi = m_pidx(32'h100);
    step(32'h100, 1, 32'h100, 1, 32'h80, 1, 32'h90, pi);
    // Alias at +ENTRIES*2: tag mismatch, then taken resolve replaces the entry.
    pc = 32'h100 + (ENTRIES << 1);
    step(pc, 0, 0, 0, 0, 0, 0, 0);
    step(pc, 1, pc, 1, 32'h200, 0, 0, m_pidx(pc));
    step(32'h100, 0, 0, 0, 0, 0, 0, 0);
    step(pc, 0, 0, 0, 0, 0, 0, 0);
    // Same-cycle lookup and update of the same entry sees pre-update state.
    step(32'h140, 1, 32'h140, 1, 32'h300, 0, 0, m_pidx(32'h140));

    for (int n = 0; n < 300; n++) begin
      pc  = ($urandom_range(0, 2) << (IDXW + 1)) | ($urandom_range(0, ENTRIES - 1) << 1);
      tk  = 1'($urandom_range(0, 1));
      tg  = $urandom_range(0, 3) << 4;
      if ($urandom_range(0, 3) != 0) begin
        ptk = m_hit(pc) && m_ctr[m_pidx(pc)] >= 2;
        step($urandom_range(0, 2 * ENTRIES - 1) << 1, $urandom_range(0, 3) != 0, pc, tk, tg,
             ptk, m_hit(pc) ? m_target[m_idx(pc)] : 0, m_pidx(pc));
      end else begin
        step(pc, 1, pc, tk, tg, 1'($urandom_range(0, 1)), $urandom_range(0, 3) << 4,
             $urandom_range(0, ENTRIES - 1));
      end
    end

    // Reset asserted while an update is pending: the write must be discarded.
    i_fetch_pc = 32'h1c0; i_ex_branch = 1'b1; i_ex_pc = 32'h1c0; i_ex_pc_plus = 32'h1c4;
    i_ex_taken = 1'b1; i_ex_target = 32'h400; i_ex_pred_taken = 1'b0; i_ex_pred_addr = '0;
    #2;
    i_rst = 1'b1;
    #1;
    check_reset_outputs("midrst");
    @(posedge clk);
    #2;
    i_ex_branch = 1'b0;
    i_rst = 1'b0;
    model_reset();
    @(posedge clk);
    #1;
    step(32'h1c0, 0, 0, 0, 0, 0, 0, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

endmodule
